exhaustive_checker: RTL
=======================

// Module: exhaustive_checker
// PURPOSE
//   Self-checking exhaustive-stimulus engine for combinational lab blocks.
//   On start, drives every input vector 0..2^N_IN-1 onto the DUT in ascending
//   order, waits SETTLE cycles per vector, compares dut_out with a golden truth
//   table and reports pass/fail, mismatch count and the first failing vector.
//   Sits between a top-level bench and any N_IN-in / N_OUT-out combinational DUT.
// PARAMETERS
//   N_IN    3     DUT input width; 2^N_IN vectors swept (1..10)
//   N_OUT   1     DUT output width
//   SETTLE  1     cycles each vector is held before sampling (>=1)
//   EXPECT  8'hE8 golden table, N_OUT*2^N_IN bits; entry v = EXPECT[v*N_OUT +: N_OUT]
// PORTS
//   clk           in   1          rising-edge clock
//   reset         in   1          asynchronous, active-high reset
//   start         in   1          begin a sweep (sampled only in IDLE/DONE)
//   stop_on_fail  in   1          1: end sweep at first mismatch
//   dut_out       in   N_OUT      DUT response
//   dut_in        out  N_IN       vector currently applied
//   busy          out  1          sweep in progress
//   done          out  1          sweep finished; results valid, held
//   pass          out  1          done && err_count==0
//   err_count     out  N_IN+1     number of mismatching vectors
//   fail_valid    out  1          at least one mismatch recorded
//   first_fail    out  N_IN       lowest-numbered failing vector
// BEHAVIOUR
//   Reset (any time, async): state=IDLE; dut_in=0, busy=0, done=0, pass=0,
//     err_count=0, fail_valid=0, first_fail=0, settle counter=0.
//   States: IDLE -> RUN -> DONE; DONE -> RUN on start; never back to IDLE w/o reset.
//   IDLE/DONE: start=1 at edge -> RUN, vec=0, cnt=0, err_count=0, fail_valid=0,
//     first_fail=0, done=0. Outputs otherwise hold.
//   RUN: busy=1, dut_in=vec. Each edge: if cnt<SETTLE-1, cnt++. If cnt==SETTLE-1:
//     compare dut_out vs EXPECT entry vec (!== ; X/Z counts as mismatch),
//     cnt=0; on mismatch err_count++, and if !fail_valid: first_fail=vec,
//     fail_valid=1.
//   End of RUN (same edge as the final compare) -> DONE, busy=0, done=1, when:
//     vec==2^N_IN-1, or (stop_on_fail && mismatch on this compare). Else vec++.
//   Latency: done rises exactly 2^N_IN*SETTLE edges after the start edge
//     (N_IN=3, SETTLE=1: 8 cycles) when no early stop.
//   start during RUN ignored. stop_on_fail sampled at each compare edge.
//   dut_in holds last applied vector in DONE; 0 in IDLE.
//   err_count width N_IN+1: cannot overflow (max 2^N_IN).
//   pass combinational from registered done/err_count; no glitches on start edge.
// TESTING
//   1 N_IN=3,SETTLE=1,EXPECT=8'hE8, DUT=majority: start -> busy 8 cycles,
//     dut_in 0..7, done=1, pass=1, err_count=0, fail_valid=0.
//   2 Same, DUT output forced 0 on vectors 5,6: done, pass=0, err_count=2,
//     fail_valid=1, first_fail=5.
//   3 Case 2 with stop_on_fail=1: done after vector 5 (6 cycles), err_count=1,
//     first_fail=5, dut_in=5.
//   4 SETTLE=3, correct DUT: each dut_in held 3 cycles, done at cycle 24, pass=1;
//     DUT with 2-cycle delay passes, with 4-cycle delay fails.
//   5 reset asserted mid-sweep at vector 4 (between edges): all outputs 0
//     immediately; new start -> full clean sweep, pass=1.
//   6 start pulsed during RUN -> ignored; start in DONE -> counters cleared,
//     second sweep identical results.

Source files
------------

// File: rtl/exhaustive_checker.sv
// Exhaustive sweep engine: applies vectors 0..2^N_IN-1 to a combinational DUT and checks each against a golden table.
// Latency: done rises 2^N_IN*SETTLE cycles after the start edge (earlier on stop_on_fail with a mismatch).
// Backpressure: none; start is ignored while a sweep is running, results hold in DONE until the next start.
module exhaustive_checker #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = 8'hE8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop_on_fail,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  first_fail
);

    localparam int NVEC = 2**N_IN;
    // Settle counter is at least one bit wide so SETTLE=1 still has a legal type.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   vec;
    logic [CW-1:0]     cnt;
    logic [N_IN:0]     err_q;
    logic              fv_q;
    logic [N_IN-1:0]   ff_q;

    logic [N_OUT-1:0]  golden [NVEC];
    logic [N_OUT-1:0]  exp_entry;
    logic              mismatch;
    logic              cmp_edge;
    logic              last_vec;
    logic              end_run;

    // Unpack the flat golden table into one entry per vector.
    for (genvar g = 0; g < NVEC; g++) begin : g_golden
        assign golden[g] = EXPECT[g*N_OUT +: N_OUT];
    end

    assign exp_entry = golden[vec];
    // Case-inequality so an X/Z response from the DUT is flagged as a failure.
    assign mismatch  = (dut_out !== exp_entry);
    assign cmp_edge  = (state == S_RUN) && (cnt == CNT_LAST);
    assign last_vec  = (vec == {N_IN{1'b1}});
    assign end_run   = cmp_edge && (last_vec || (stop_on_fail && mismatch));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE/DONE wait for start, RUN ends on the final (or stopping) compare.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)   state_nxt = S_RUN;
            S_RUN:          if (end_run) state_nxt = S_DONE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // Sweep datapath: vector/settle counters and the error bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec   <= '0;
            cnt   <= '0;
            err_q <= '0;
            fv_q  <= 1'b0;
            ff_q  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec   <= '0;
                        cnt   <= '0;
                        err_q <= '0;
                        fv_q  <= 1'b0;
                        ff_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (mismatch) begin
                            err_q <= err_q + 1'b1;
                            if (!fv_q) begin
                                ff_q <= vec;
                                fv_q <= 1'b1;
                            end
                        end
                        // The last applied vector stays on dut_in once the sweep ends.
                        if (!end_run) begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in     = vec;
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule
